video_pattern_gen: RTL and testbench
====================================

# video_pattern_gen

Video source block: generates raster timing (data-enable, horizontal sync, vertical sync) and 24-bit test-pattern pixels for one clock domain. It sits at the head of the pixel pipeline and drives the VDE and pixel inputs of downstream processing stages, such as the grayscale converter, so that those stages run without a camera. The block is fully parameterised for any progressive video mode. Pixel byte order is red [23:16], blue [15:8], green [7:0], matching the rest of the pipeline.

## Interface
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (clocks)
- H_SYNC, 40, horizontal sync width (clocks)
- H_BP, 220, horizontal back porch (clocks)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vertical sync width (lines)
- V_BP, 20, vertical back porch (lines)
- SYNC_POL, 1, sync active level (1 = active-high)
- CHECK_LOG2, 5, log2 of checkerboard square size in pixels

Ports:
- i_clk  input  1  pixel clock; all logic on the rising edge
- i_rstN  input  1  reset; synchronous, active-low
- i_pattern  input  2  pattern select: 0 bars, 1 ramp, 2 checker, 3 solid
- i_solidColor  input  24  colour for pattern 3
- o_VDE  output  1  active-video data enable
- o_HSync  output  1  horizontal sync
- o_VSync  output  1  vertical sync
- o_frameStart  output  1  one-clock pulse with pixel (0,0)
- o_pixelData  output  24  pixel; 0 when o_VDE = 0

## Operation
- Counters:
  - hCnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - vCnt runs 0..V_TOTAL-1 and increments when hCnt wraps.
  - Both counters wrap to 0 together at the end of a frame.
- Regions:
  - Active region: hCnt < H_ACTIVE and vCnt < V_ACTIVE.
  - HSync asserted for H_ACTIVE+H_FP ≤ hCnt < H_ACTIVE+H_FP+H_SYNC, on every line including blanking lines.
  - VSync asserted for whole lines V_ACTIVE+V_FP ≤ vCnt < V_ACTIVE+V_FP+V_SYNC, from hCnt = 0 of the first such line.
- Pattern latch: i_pattern and i_solidColor are captured into internal registers only when (hCnt,vCnt) = (0,0). A pattern change never takes effect mid-frame.
- Pattern 0, colour bars:
  - Eight bars, each BAR_W = H_ACTIVE/8 wide (integer division). Bar 7 absorbs the remainder.
  - Bar order: white FFFFFF, yellow FF00FF, cyan 00FFFF, green 0000FF, magenta FFFF00, red FF0000, blue 00FF00, black 000000 (R,B,G byte order).
  - No divider: a bar-position counter clears at line start and advances the bar index on reaching BAR_W-1. The bar index saturates at 7.
- Pattern 1, gray ramp: all three bytes = hCnt[7:0].
- Pattern 2, checkerboard:
  - FFFFFF when hCnt[CHECK_LOG2] ^ vCnt[CHECK_LOG2] = 0.
  - 000000 otherwise.
- Pattern 3, solid: the latched i_solidColor.
- Outside the active region, o_pixelData = 0.

## Timing
- All outputs are registered. Each output is a function of the (hCnt,vCnt) value before the clock edge; the counters advance on the same edge. Latency is 1 clock from counter state to output.
- Reset (i_rstN = 0 at an edge):
  - Counters, bar state and latched pattern go to 0. The latched colour goes to 0.
  - o_VDE = 0, o_frameStart = 0, o_pixelData = 0.
  - o_HSync = o_VSync = ~SYNC_POL.
- First edge after reset release:
  - o_VDE = 1 and o_frameStart = 1, with the pixel for (0,0).
  - The pattern is latched from the inputs at that edge.
- Reset asserted mid-frame: all outputs take reset values at that edge. The next frame restarts at (0,0) with no partial line.
- o_frameStart is high exactly one clock per frame, coincident with the first o_VDE of the frame.
- o_VDE is high exactly H_ACTIVE consecutive clocks per active line and V_ACTIVE lines per frame. Frame period is H_TOTAL*V_TOTAL clocks.

## Test plan
Bench parameters: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=24); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); SYNC_POL=1; CHECK_LOG2=1.
- Reset then release, i_pattern=0:
  - o_frameStart is pulsed one clock after release, then every 192 clocks.
  - o_VDE: 16 high / 8 low per line for 4 lines, then low for 4 lines.
  - o_HSync high for clocks 18–20 of each line.
  - o_VSync high for lines 5–6.
- Colour bars (i_pattern=0), bar width 2:
  - Line 0 pixels are FFFFFF ×2, FF00FF ×2, 00FFFF ×2, 0000FF ×2, FFFF00 ×2, FF0000 ×2, 00FF00 ×2, 000000 ×2.
  - o_pixelData = 0 during blanking.
- Ramp and checker:
  - i_pattern=1: line 2 pixels are 000000, 010101 … 0F0F0F.
  - i_pattern=2: line 0 is FFFFFF,FFFFFF,000000,000000, repeating; line 2 is inverted.
- Mid-frame pattern change:
  - Switch i_pattern 0→3 with i_solidColor=123456 on line 1 of the frame.
  - The remainder of that frame stays bars; the next frame is all 123456.
- Reset mid-frame:
  - Assert i_rstN=0 for 3 clocks at line 2 pixel 7.
  - Outputs are at reset values during the reset (syncs low).
  - After release, o_frameStart=1 on the first edge and a full 192-clock frame follows.

Source files
------------

// File: rtl/video_pattern_gen.sv
// Raster timing generator (DE, HSync, VSync) with selectable 24-bit test patterns.
// Latency: 1 clock from counter state to every output; all outputs registered.
// Backpressure: none, free-running pixel source; downstream must accept every clock.
//
// Ports:
//   i_clk         pixel clock, rising edge
//   i_rstN        synchronous active-low reset
//   i_pattern     0 bars, 1 gray ramp, 2 checkerboard, 3 solid (latched at frame start)
//   i_solidColor  colour for pattern 3 (latched at frame start)
//   o_VDE         active-video data enable
//   o_HSync       horizontal sync, polarity SYNC_POL
//   o_VSync       vertical sync, polarity SYNC_POL
//   o_frameStart  one-clock pulse coincident with pixel (0,0)
//   o_pixelData   pixel {R,B,G}, zero outside the active region
module video_pattern_gen #(
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 110,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 220,
  parameter int V_ACTIVE   = 720,
  parameter int V_FP       = 5,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 20,
  parameter bit SYNC_POL   = 1'b1,
  parameter int CHECK_LOG2 = 5
) (
  input  logic        i_clk,
  input  logic        i_rstN,
  input  logic [1:0]  i_pattern,
  input  logic [23:0] i_solidColor,
  output logic        o_VDE,
  output logic        o_HSync,
  output logic        o_VSync,
  output logic        o_frameStart,
  output logic [23:0] o_pixelData
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  // Horizontal counter is at least 8 bits so the ramp can take hCnt[7:0]
  // directly; both counters must also contain the checkerboard bit.
  localparam int H_MIN = (CHECK_LOG2 + 1 > 8) ? CHECK_LOG2 + 1 : 8;
  localparam int HW    = ($clog2(H_TOTAL) > H_MIN) ? $clog2(H_TOTAL) : H_MIN;
  localparam int VW    = ($clog2(V_TOTAL) > CHECK_LOG2 + 1) ? $clog2(V_TOTAL) : CHECK_LOG2 + 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] BAR_LAST = HW'(BAR_W - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [HW-1:0] bar_pos;
  logic [2:0]    bar_idx;
  logic [1:0]    pat_q;
  logic [23:0]   col_q;

  logic          frame_first;
  logic          active;
  logic          hs_on;
  logic          vs_on;
  logic [1:0]    pat_eff;
  logic [23:0]   col_eff;
  logic [23:0]   bar_rgb;
  logic [23:0]   pix_next;

  always_comb begin
    frame_first = (h_cnt == '0) && (v_cnt == '0);
    // Pixel (0,0) is rendered with the values being latched on this same
    // edge, so the first pixel of a frame already reflects the new pattern.
    pat_eff = frame_first ? i_pattern    : pat_q;
    col_eff = frame_first ? i_solidColor : col_q;
    active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_on   = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs_on   = (v_cnt >= VS_START) && (v_cnt < VS_END);

    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;  // white
      3'd1:    bar_rgb = 24'hFF00FF;  // yellow
      3'd2:    bar_rgb = 24'h00FFFF;  // cyan
      3'd3:    bar_rgb = 24'h0000FF;  // green
      3'd4:    bar_rgb = 24'hFFFF00;  // magenta
      3'd5:    bar_rgb = 24'hFF0000;  // red
      3'd6:    bar_rgb = 24'h00FF00;  // blue
      default: bar_rgb = 24'h000000;  // black
    endcase

    pix_next = '0;
    if (active) begin
      case (pat_eff)
        2'd0:    pix_next = bar_rgb;
        2'd1:    pix_next = {3{h_cnt[7:0]}};
        2'd2:    pix_next = (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) ? 24'h000000 : 24'hFFFFFF;
        default: pix_next = col_eff;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      h_cnt        <= '0;
      v_cnt        <= '0;
      bar_pos      <= '0;
      bar_idx      <= '0;
      pat_q        <= '0;
      col_q        <= '0;
      o_VDE        <= 1'b0;
      o_HSync      <= ~SYNC_POL;
      o_VSync      <= ~SYNC_POL;
      o_frameStart <= 1'b0;
      o_pixelData  <= '0;
    end else begin
      if (frame_first) begin
        pat_q <= i_pattern;
        col_q <= i_solidColor;
      end

      if (h_cnt == H_LAST) begin
        h_cnt   <= '0;
        v_cnt   <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        bar_pos <= '0;
        bar_idx <= '0;
      end else begin
        h_cnt <= h_cnt + HW'(1);
        // Divider-free bar index; saturating at 7 lets the last bar absorb
        // any remainder of H_ACTIVE/8.
        if (bar_pos == BAR_LAST) begin
          bar_pos <= '0;
          if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_pos <= bar_pos + HW'(1);
        end
      end

      o_VDE        <= active;
      o_HSync      <= hs_on ? SYNC_POL : ~SYNC_POL;
      o_VSync      <= vs_on ? SYNC_POL : ~SYNC_POL;
      o_frameStart <= frame_first;
      o_pixelData  <= pix_next;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
module tb_video_pattern_gen;

  typedef struct packed {
    logic        vde;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [23:0] pix;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pattern = 2'd0;
  logic [23:0] solid = 24'h0;
  logic        vde, hsync, vsync, fstart;
  logic [23:0] pix;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  obs_t exp_q[$];

  // Expected-state tracking: raster position before the next edge and the
  // pattern/colour the current frame was started with.
  int          eh = 0;
  int          ev = 0;
  logic [1:0]  lp = 2'd0;
  logic [23:0] lc = 24'h0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFF00FF, 24'h00FFFF, 24'h0000FF,
                            24'hFFFF00, 24'hFF0000, 24'h00FF00, 24'h000000};

  video_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .CHECK_LOG2(1)
  ) dut (
    .i_clk        (clk),
    .i_rstN       (rst_n),
    .i_pattern    (pattern),
    .i_solidColor (solid),
    .o_VDE        (vde),
    .o_HSync      (hsync),
    .o_VSync      (vsync),
    .o_frameStart (fstart),
    .o_pixelData  (pix)
  );

  always #5 clk = ~clk;

  // One clock of stimulus: drive inputs at the falling edge and push the
  // response expected right after the following rising edge.
  task automatic step(input logic rst, input logic [1:0] p, input logic [23:0] c);
    obs_t e;
    @(negedge clk);
    rst_n   = ~rst;
    pattern = p;
    solid   = c;
    if (rst) begin
      e  = '0;  // syncs idle low with SYNC_POL=1
      eh = 0;
      ev = 0;
      lp = 2'd0;
      lc = 24'h0;
    end else begin
      if (eh == 0 && ev == 0) begin
        lp = p;
        lc = c;
      end
      e.vde = (eh < 16) && (ev < 4);
      e.hs  = (eh >= 18) && (eh <= 20);
      e.vs  = (ev == 5) || (ev == 6);
      e.fs  = (eh == 0) && (ev == 0);
      e.pix = 24'h0;
      if (e.vde) begin
        case (lp)
          2'd0:    e.pix = bars[eh / 2];
          2'd1:    e.pix = {3{8'(eh)}};
          2'd2:    e.pix = ((((eh / 2) ^ (ev / 2)) & 1) == 0) ? 24'hFFFFFF : 24'h000000;
          default: e.pix = lc;
        endcase
      end
      eh = eh + 1;
      if (eh == 24) begin
        eh = 0;
        ev = (ev == 7) ? 0 : ev + 1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input logic [1:0] p, input logic [23:0] c);
    for (int i = 0; i < n; i++) step(1'b0, p, c);
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 2'd0, 24'h0);
  endtask

  // Monitor: every clock is an output beat; compare it with the oldest
  // expectation once the rising-edge update has settled.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = '{vde: vde, hs: hsync, vs: vsync, fs: fstart, pix: pix};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL beat cyc=%0d: got vde=%b hs=%b vs=%b fs=%b pix=%h, want vde=%b hs=%b vs=%b fs=%b pix=%h",
                   cyc, a.vde, a.hs, a.vs, a.fs, a.pix, e.vde, e.hs, e.vs, e.fs, e.pix);
        end
      end
    end
  end

  initial begin
    hold_reset(3);                       // reset state, syncs low
    run(192, 2'd0, 24'h0);               // bars frame, timing and frameStart
    run(192, 2'd1, 24'h0);               // ramp
    run(192, 2'd2, 24'h0);               // checkerboard
    run(24,  2'd0, 24'h0);               // bars, line 0
    run(168, 2'd3, 24'h123456);          // change mid-frame: must stay bars
    run(192, 2'd3, 24'h123456);          // next frame fully solid
    run(55,  2'd1, 24'h0);               // up to line 2 pixel 6
    hold_reset(3);                       // reset lands at line 2 pixel 7
    run(192, 2'd2, 24'h0);               // full frame after restart
    run(5,   2'd0, 24'h0);               // start of the following frame
    @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
